// File: rtl/copy_stage_pkg.sv
// Shared widths, packet field offsets and FSM encoding for the packet copy stage.
package copy_stage_pkg;

    localparam int DEF_HDR_W  = 11;
    localparam int DEF_DEST_W = 7;
    localparam int DEF_CNT_W  = 1;
    localparam int DEF_DATA_W = 18;
    localparam int DEF_STRIDE = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Input packet field offsets, LSB upwards: DATA | CNT | FLG | LRC | LRO | DEST | HDR
    function automatic int cnt_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int flg_bit(input int data_w, input int cnt_w);
        return data_w + cnt_w;
    endfunction

    function automatic int lrc_bit(input int data_w, input int cnt_w);
        return data_w + cnt_w + 1;
    endfunction

    function automatic int lro_bit(input int data_w, input int cnt_w);
        return data_w + cnt_w + 2;
    endfunction

    function automatic int dest_lsb(input int data_w, input int cnt_w);
        return data_w + cnt_w + 3;
    endfunction

    function automatic int hdr_lsb(input int data_w, input int cnt_w, input int dest_w);
        return data_w + cnt_w + 3 + dest_w;
    endfunction

endpackage

// File: rtl/copy_dest_gen.sv
// Per-copy destination and link-route select: dest + k*STRIDE (wrapping), LRO for the original, LRC for copies.
module copy_dest_gen #(
    parameter int DEST_W = 7,
    parameter int CNT_W  = 1,
    parameter int STRIDE = 1
) (
    input  logic [DEST_W-1:0] dest,
    input  logic              lro,
    input  logic              lrc,
    input  logic [CNT_W-1:0]  k,
    output logic [DEST_W-1:0] dest_out,
    output logic              lr
);

    localparam logic [DEST_W-1:0] STRIDE_M = DEST_W'(STRIDE);

    logic [DEST_W-1:0] k_ext;

    assign k_ext    = DEST_W'(k);
    assign dest_out = dest + k_ext * STRIDE_M;
    assign lr       = (k == '0) ? lro : lrc;

endmodule

// File: rtl/copy_stage_n.sv
// Packet copy stage: each accepted packet is emitted CNT+1 times with stepped destinations.
module copy_stage_n
    import copy_stage_pkg::*;
#(
    parameter int HDR_W  = DEF_HDR_W,
    parameter int DEST_W = DEF_DEST_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STRIDE = DEF_STRIDE,
    parameter int IN_W   = HDR_W + DEST_W + 3 + CNT_W + DATA_W,
    parameter int OUT_W  = HDR_W + DEST_W + 2 + DATA_W
) (
    input  logic             CLK,
    input  logic             MR_n,
    input  logic             Send_in,
    output logic             Ack_out,
    input  logic [IN_W-1:0]  PACKET_IN,
    output logic             Send_out,
    input  logic             Ack_in,
    output logic [OUT_W-1:0] PACKET_OUT,
    output logic             Busy
);

    localparam int CNT_LSB  = cnt_lsb(DATA_W);
    localparam int FLG_BIT  = flg_bit(DATA_W, CNT_W);
    localparam int LRC_BIT  = lrc_bit(DATA_W, CNT_W);
    localparam int LRO_BIT  = lro_bit(DATA_W, CNT_W);
    localparam int DEST_LSB = dest_lsb(DATA_W, CNT_W);
    localparam int HDR_LSB  = hdr_lsb(DATA_W, CNT_W, DEST_W);

    state_t            state;
    logic              rst_done;
    logic [IN_W-1:0]   hold;
    logic [CNT_W-1:0]  k;
    logic [OUT_W-1:0]  out_q;

    logic              in_xfer;
    logic              out_xfer;
    logic              last;
    logic [IN_W-1:0]   src;
    logic [CNT_W-1:0]  src_k;
    logic [DEST_W-1:0] gen_dest;
    logic              gen_lr;
    logic [OUT_W-1:0]  next_out;

    // Handshake: a transfer happens on a CLK rise where valid (Send_*) and ready (Ack_*) are both high;
    // Ack_out rises in EMIT only on the last copy's transfer cycle, giving a zero-bubble reload.
    assign out_xfer = (state == ST_EMIT) && Ack_in;
    assign last     = (k == hold[CNT_LSB +: CNT_W]);
    assign Ack_out  = ((state == ST_IDLE) && rst_done) || (out_xfer && last);
    assign in_xfer  = Send_in && Ack_out;

    // The next output word is built either from a freshly accepted packet (copy 0) or from the held one.
    assign src   = in_xfer ? PACKET_IN : hold;
    assign src_k = in_xfer ? '0 : k + 1'b1;

    copy_dest_gen #(
        .DEST_W (DEST_W),
        .CNT_W  (CNT_W),
        .STRIDE (STRIDE)
    ) u_dest_gen (
        .dest     (src[DEST_LSB +: DEST_W]),
        .lro      (src[LRO_BIT]),
        .lrc      (src[LRC_BIT]),
        .k        (src_k),
        .dest_out (gen_dest),
        .lr       (gen_lr)
    );

    assign next_out = {src[HDR_LSB +: HDR_W], gen_dest, gen_lr, src[FLG_BIT], src[DATA_W-1:0]};

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            state    <= ST_IDLE;
            rst_done <= 1'b0;
            hold     <= '0;
            k        <= '0;
            out_q    <= '0;
        end else begin
            rst_done <= 1'b1;
            if (in_xfer) begin
                hold  <= PACKET_IN;
                k     <= '0;
                out_q <= next_out;
                state <= ST_EMIT;
            end else if (out_xfer && !last) begin
                k     <= src_k;
                out_q <= next_out;
            end else if (out_xfer) begin
                state <= ST_IDLE;
            end
        end
    end

    assign Send_out   = (state == ST_EMIT);
    assign Busy       = (state == ST_EMIT);
    assign PACKET_OUT = out_q;

endmodule

// File: tb/tb_copy_stage_n.sv
// Directed bench for copy_stage_n: default build plus a CNT_W=3 / STRIDE=2 build.
module tb_copy_stage_n;

    logic clk;
    logic mr_n;

    logic        a_send_in, a_ack_out, a_send_out, a_ack_in, a_busy;
    logic [39:0] a_pkt_in;
    logic [37:0] a_pkt_out;

    logic        b_send_in, b_ack_out, b_send_out, b_ack_in, b_busy;
    logic [41:0] b_pkt_in;
    logic [37:0] b_pkt_out;

    int n_checks = 0;
    int n_err    = 0;

    copy_stage_n dut_a (
        .CLK        (clk),
        .MR_n       (mr_n),
        .Send_in    (a_send_in),
        .Ack_out    (a_ack_out),
        .PACKET_IN  (a_pkt_in),
        .Send_out   (a_send_out),
        .Ack_in     (a_ack_in),
        .PACKET_OUT (a_pkt_out),
        .Busy       (a_busy)
    );

    copy_stage_n #(.CNT_W(3), .STRIDE(2)) dut_b (
        .CLK        (clk),
        .MR_n       (mr_n),
        .Send_in    (b_send_in),
        .Ack_out    (b_ack_out),
        .PACKET_IN  (b_pkt_in),
        .Send_out   (b_send_out),
        .Ack_in     (b_ack_in),
        .PACKET_OUT (b_pkt_out),
        .Busy       (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [10:0] hdr;
        logic [6:0]  dest;
        logic        lro;
        logic        lrc;
        logic        flg;
        logic        cnt;
        logic [17:0] data;
        int          n;
        logic [6:0]  d0;
        logic        l0;
        logic [6:0]  d1;
        logic        l1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] mk_out(input logic [10:0] hdr, input logic [6:0] dest,
                                           input logic lr, input logic flg, input logic [17:0] data);
        return {hdr, dest, lr, flg, data};
    endfunction

    task automatic run_vector(input vec_t v, input int idx);
        @(negedge clk);
        a_send_in = 1'b1;
        a_ack_in  = 1'b1;
        a_pkt_in  = {v.hdr, v.dest, v.lro, v.lrc, v.flg, v.cnt, v.data};
        #1 check($sformatf("v%0d_ack_idle", idx), a_ack_out, 1);
        @(negedge clk);
        a_send_in = 1'b0;
        #1;
        check($sformatf("v%0d_send0", idx), a_send_out, 1);
        check($sformatf("v%0d_copy0", idx), a_pkt_out, mk_out(v.hdr, v.d0, v.l0, v.flg, v.data));
        check($sformatf("v%0d_ack0", idx), a_ack_out, (v.n == 1));
        if (v.n == 2) begin
            @(negedge clk);
            #1;
            check($sformatf("v%0d_copy1", idx), a_pkt_out, mk_out(v.hdr, v.d1, v.l1, v.flg, v.data));
            check($sformatf("v%0d_ack1", idx), a_ack_out, 1);
        end
        @(negedge clk);
        #1;
        check($sformatf("v%0d_send_end", idx), a_send_out, 0);
        check($sformatf("v%0d_busy_end", idx), a_busy, 0);
    endtask

    initial begin
        logic [6:0] b_dests[6];
        b_dests = '{7'd100, 7'd102, 7'd104, 7'd106, 7'd108, 7'd110};

        vecs[0] = '{11'h123, 7'd5,   1'b1, 1'b0, 1'b1, 1'b0, 18'h2AAAA, 1, 7'd5,   1'b1, 7'd0,   1'b0};
        vecs[1] = '{11'h456, 7'd5,   1'b0, 1'b1, 1'b0, 1'b1, 18'h15555, 2, 7'd5,   1'b0, 7'd6,   1'b1};
        vecs[2] = '{11'h7FF, 7'h7F,  1'b1, 1'b0, 1'b1, 1'b1, 18'h3FFFF, 2, 7'h7F,  1'b1, 7'h00,  1'b0};
        vecs[3] = '{11'h001, 7'h40,  1'b1, 1'b1, 1'b0, 1'b1, 18'h00001, 2, 7'h40,  1'b1, 7'h41,  1'b1};
        vecs[4] = '{11'h3C3, 7'h7F,  1'b0, 1'b1, 1'b1, 1'b0, 18'h0F0F0, 1, 7'h7F,  1'b0, 7'd0,   1'b0};

        mr_n      = 1'b0;
        a_send_in = 1'b0;
        a_ack_in  = 1'b0;
        a_pkt_in  = '0;
        b_send_in = 1'b0;
        b_ack_in  = 1'b0;
        b_pkt_in  = '0;

        // Reset state
        #1;
        check("rst_send_out", a_send_out, 0);
        check("rst_busy", a_busy, 0);
        check("rst_pkt_out", a_pkt_out, 0);
        check("rst_ack_out", a_ack_out, 0);
        @(negedge clk);
        #1 check("rst_ack_after_edge", a_ack_out, 0);
        mr_n = 1'b1;
        #1 check("rel_ack_before_edge", a_ack_out, 0);
        @(negedge clk);
        #1;
        check("rel_ack_after_edge", a_ack_out, 1);
        check("rel_b_ack_after_edge", b_ack_out, 1);

        for (int i = 0; i < 5; i++) run_vector(vecs[i], i);

        // Back-to-back streams: second packet accepted on the first stream's last copy
        @(negedge clk);
        a_ack_in  = 1'b1;
        a_send_in = 1'b1;
        a_pkt_in  = {11'h0AA, 7'd10, 1'b1, 1'b0, 1'b0, 1'b1, 18'h11111};
        @(negedge clk);
        a_pkt_in  = {11'h155, 7'd20, 1'b0, 1'b1, 1'b1, 1'b1, 18'h22222};
        #1;
        check("b2b_p1_c0", a_pkt_out, mk_out(11'h0AA, 7'd10, 1'b1, 1'b0, 18'h11111));
        check("b2b_p1_c0_ack", a_ack_out, 0);
        @(negedge clk);
        #1;
        check("b2b_p1_c1", a_pkt_out, mk_out(11'h0AA, 7'd11, 1'b0, 1'b0, 18'h11111));
        check("b2b_p1_c1_ack", a_ack_out, 1);
        @(negedge clk);
        a_send_in = 1'b0;
        #1;
        check("b2b_p2_c0_send", a_send_out, 1);
        check("b2b_p2_c0", a_pkt_out, mk_out(11'h155, 7'd20, 1'b0, 1'b1, 18'h22222));
        @(negedge clk);
        #1 check("b2b_p2_c1", a_pkt_out, mk_out(11'h155, 7'd21, 1'b1, 1'b1, 18'h22222));
        @(negedge clk);
        #1 check("b2b_idle", a_send_out, 0);

        // Six copies, stride 2, with Ack_in alternating low/high
        @(negedge clk);
        b_send_in = 1'b1;
        b_ack_in  = 1'b0;
        b_pkt_in  = {11'h2AB, 7'd100, 1'b1, 1'b0, 1'b1, 3'd5, 18'h01234};
        @(negedge clk);
        b_send_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b_ack_in = 1'b0;
            #1;
            check($sformatf("stride_c%0d_stall", i), b_pkt_out,
                  mk_out(11'h2AB, b_dests[i], (i == 0), 1'b1, 18'h01234));
            check($sformatf("stride_c%0d_stall_ack", i), b_ack_out, 0);
            @(negedge clk);
            b_ack_in = 1'b1;
            #1;
            check($sformatf("stride_c%0d_go", i), b_pkt_out,
                  mk_out(11'h2AB, b_dests[i], (i == 0), 1'b1, 18'h01234));
            check($sformatf("stride_c%0d_go_ack", i), b_ack_out, (i == 5));
            @(negedge clk);
        end
        #1 check("stride_idle", b_send_out, 0);

        // Reset during the second of three copies
        @(negedge clk);
        b_send_in = 1'b1;
        b_ack_in  = 1'b1;
        b_pkt_in  = {11'h070, 7'd50, 1'b0, 1'b1, 1'b0, 3'd2, 18'h3C3C3};
        @(negedge clk);
        b_send_in = 1'b0;
        #1 check("mr_c0", b_pkt_out, mk_out(11'h070, 7'd50, 1'b0, 1'b0, 18'h3C3C3));
        @(negedge clk);
        #1 check("mr_c1", b_pkt_out, mk_out(11'h070, 7'd52, 1'b1, 1'b0, 18'h3C3C3));
        #1 mr_n = 1'b0;
        #1;
        check("mr_send_out", b_send_out, 0);
        check("mr_busy", b_busy, 0);
        check("mr_pkt_out", b_pkt_out, 0);
        check("mr_ack_out", b_ack_out, 0);
        @(negedge clk);
        mr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check($sformatf("mr_after_%0d", i), b_send_out, 0);
        end
        check("mr_ack_after", b_ack_out, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
